// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared state encoding and ID width helper for mult_scheduler
package mult_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RELEASE = 2'd2, RESP = 2'd3} state_t;
  function automatic int ID_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant, searching upward from last+1
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ID_W(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant
);
  // Walk from farthest to nearest so the nearest valid requester is the final write
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) grant = N'(1) << ((int'(last) + k) % N);
  end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin sharing of one start/done multiplier among NUM_REQ clients,
// with a watchdog that turns a hung multiplier into an error response.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  localparam int IW     = ID_W(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IW-1:0]            resp_id,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic                     resp_err,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product
);
  localparam int WW = $clog2(TIMEOUT);
  state_t             state_q, state_d;
  logic [IW-1:0]      last_q, last_d, resp_id_q, resp_id_d, sel;
  logic [WW-1:0]      wd_q, wd_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] resp_product_q, resp_product_d;
  logic               resp_err_q, resp_err_d, resp_valid_q, resp_valid_d, mul_start_q, mul_start_d;
  logic [NUM_REQ-1:0] grant;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req_valid), .last(last_q), .grant(grant));
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) sel = IW'(i);
  end
  // A still-high mul_done means the multiplier has not returned to idle; hold off new work
  assign req_ready = (state_q == IDLE && !mul_done) ? grant : '0;
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    wd_d           = wd_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    resp_id_d      = resp_id_q;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    resp_valid_d   = resp_valid_q;
    mul_start_d    = mul_start_q;
    case (state_q)
      IDLE: if (|req_ready) begin
        state_d     = RUN;
        last_d      = sel;
        resp_id_d   = sel;
        wd_d        = '0;
        mul_a_d     = req_a[sel*WIDTH +: WIDTH];
        mul_b_d     = req_b[sel*WIDTH +: WIDTH];
        mul_start_d = 1'b1;
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        if (mul_done || wd_q == WW'(TIMEOUT - 1)) begin
          state_d        = RELEASE;
          mul_start_d    = 1'b0;
          resp_product_d = mul_done ? mul_product : '0;
          resp_err_d     = !mul_done;
        end
      end
      RELEASE: if (!mul_done) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: if (resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= IW'(NUM_REQ - 1);
      wd_q           <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      resp_valid_q   <= 1'b0;
      mul_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      wd_q           <= wd_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      resp_id_q      <= resp_id_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      resp_valid_q   <= resp_valid_d;
      mul_start_q    <= mul_start_d;
    end
  end
  assign mul_start    = mul_start_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign resp_err     = resp_err_q;
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: scoreboard bench with a behavioural start/done multiplier that can be stuck
module tb_mult_scheduler;
  localparam int N = 4, W = 8, TO = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic resp_valid, resp_ready = 1'b1, resp_err, mul_start, mul_done;
  logic [1:0] resp_id;
  logic [2*W-1:0] resp_product, mul_product;
  logic [W-1:0] mul_a, mul_b;
  logic [4:0] mcnt;
  bit stuck = 1'b0;
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  typedef struct packed {logic [1:0] id; logic [15:0] p; logic e;} exp_t;
  exp_t sb[$];

  mult_scheduler #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .resp_err(resp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: LOAD + W SHIFT cycles, done held until start drops
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcnt <= '0; mul_done <= 1'b0; mul_product <= '0;
    end else if (!mul_start) begin
      mcnt <= '0; mul_done <= 1'b0;
    end else if (!mul_done && !stuck) begin
      if (mcnt == 5'(W + 1)) begin
        mul_done <= 1'b1; mul_product <= 16'(mul_a) * 16'(mul_b); mcnt <= '0;
      end else mcnt <= mcnt + 1'b1;
    end

  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back({2'(i), stuck ? 16'd0 : 16'(req_a[i*W +: W]) * 16'(req_b[i*W +: W]), stuck});
          acc_cyc <= cyc;
        end

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1;
    @(negedge clk);
    while (!req_ready[i] && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(output bit ok, output exp_t got, output exp_t ex, output int lat);
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    ok = resp_valid && sb.size() > 0;
    got = {resp_id, resp_product, resp_err};
    lat = cyc - acc_cyc;
    ex = ok ? sb.pop_front() : '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; repeat (2) @(posedge clk); #1;
    checks++;
    if ({mul_start, resp_valid, resp_err, resp_id, resp_product, mul_a, mul_b} !== '0) begin
      failures++; $display("FAIL reset_outputs: start=%b valid=%b err=%b id=%0d p=%0d a=%0d b=%0d, want all 0",
        mul_start, resp_valid, resp_err, resp_id, resp_product, mul_a, mul_b);
    end
    rst_n = 1'b1; @(posedge clk); #1;
  endtask

  task automatic test_single;
    bit ok; exp_t got, ex; int lat;
    send(2, 8'd13, 8'd11);
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.p !== 16'd143 || got.id !== 2'd2 || got.e !== 1'b0) begin
      failures++; $display("FAIL single: ok=%b got=%h want=%h (id 2 p 143)", ok, got, ex);
    end
    checks++;
    if (lat != W + 6) begin failures++; $display("FAIL single_latency: got %0d want %0d", lat, W + 6); end
  endtask

  task automatic test_round_robin;
    bit ok; exp_t got, ex; int lat;
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
    req_a = {8'd17, 8'd100, 8'd3, 8'd255};
    req_b = {8'd15, 8'd2, 8'd7, 8'd255};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_resp(ok, got, ex, lat);
      checks++;
      if (!ok || got !== ex || got.id !== order[k]) begin
        failures++; $display("FAIL rr_%0d: ok=%b got id=%0d p=%0d e=%b want id=%0d p=%0d e=%b",
          k, ok, got.id, got.p, got.e, order[k], ex.p, ex.e);
      end
    end
    req_valid = '0;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL rr_extra: %0d unexpected accepts, want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    bit ok; exp_t got, ex, snap, ex1; int lat, n = 0, hs;
    resp_ready = 1'b0;
    send(1, 8'd9, 8'd9);
    req_a[7:0] = 8'd2; req_b[7:0] = 8'd50; req_valid[0] = 1'b1;
    @(negedge clk);
    while (!resp_valid && n < 200) begin @(negedge clk); n++; end
    snap = {resp_id, resp_product, resp_err};
    ex1 = sb.size() > 0 ? sb.pop_front() : '0;
    checks++;
    if (!resp_valid || snap !== ex1 || snap.p !== 16'd81) begin
      failures++; $display("FAIL bp_first: valid=%b got=%h want=%h", resp_valid, snap, ex1);
    end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (!resp_valid || {resp_id, resp_product, resp_err} !== snap || req_ready !== '0 || mul_start !== 1'b0) begin
        failures++; $display("FAIL bp_hold: valid=%b fields=%h ready=%b start=%b want 1 %h 0000 0",
          resp_valid, {resp_id, resp_product, resp_err}, req_ready, mul_start, snap);
      end
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk); hs = cyc;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || cyc != hs + 1) begin
      failures++; $display("FAIL b2b_accept: ready=%b cyc_gap=%0d want 0001 gap 1", req_ready, cyc - hs);
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.p !== 16'd100 || got.id !== 2'd0) begin
      failures++; $display("FAIL b2b_resp: ok=%b got=%h want=%h", ok, got, ex);
    end
  endtask

  task automatic test_stuck;
    bit ok; exp_t got, ex; int lat;
    stuck = 1'b1;
    send(3, 8'd5, 8'd6);
    wait_resp(ok, got, ex, lat);
    stuck = 1'b0;
    checks++;
    if (!ok || got !== ex || got.e !== 1'b1 || got.p !== 16'd0) begin
      failures++; $display("FAIL stuck_resp: ok=%b got id=%0d p=%0d e=%b want id=3 p=0 e=1", ok, got.id, got.p, got.e);
    end
    checks++;
    if (lat != TO + 2) begin failures++; $display("FAIL stuck_latency: got %0d want %0d", lat, TO + 2); end
    send(3, 8'd7, 8'd8);
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.p !== 16'd56 || got.e !== 1'b0 || lat != W + 6) begin
      failures++; $display("FAIL stuck_recover: ok=%b got p=%0d e=%b lat=%0d want p=56 e=0 lat=%0d", ok, got.p, got.e, lat, W + 6);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; exp_t got, ex; int lat, n = 0;
    req_a[15:8] = 8'd3; req_b[15:8] = 8'd4; req_valid[1] = 1'b1;
    @(negedge clk);
    while (!req_ready[1] && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (3) @(posedge clk); #2;
    checks++;
    if (mul_start !== 1'b1) begin failures++; $display("FAIL mid_run: start=%b want 1", mul_start); end
    rst_n = 1'b0; sb.delete(); #1;
    checks++;
    if ({mul_start, resp_valid, resp_err, resp_id, resp_product, mul_a, mul_b} !== '0) begin
      failures++; $display("FAIL mid_reset_async: start=%b valid=%b a=%0d b=%0d want 0", mul_start, resp_valid, mul_a, mul_b);
    end
    req_a = {8'd9, 16'd0, 8'd6}; req_b = {8'd9, 16'd0, 8'd7}; req_valid = 4'b1001;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_priority: ready=%b want 0001", req_ready); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.id !== 2'd0 || got.p !== 16'd42) begin
      failures++; $display("FAIL mid_resp0: ok=%b got=%h want=%h (id 0 p 42)", ok, got, ex);
    end
    wait_resp(ok, got, ex, lat);
    req_valid = '0;
    checks++;
    if (!ok || got !== ex || got.id !== 2'd3 || got.p !== 16'd81) begin
      failures++; $display("FAIL mid_resp3: ok=%b got=%h want=%h (id 3 p 81)", ok, got, ex);
    end
  endtask

  task automatic test_edges;
    bit ok; exp_t got, ex; int lat;
    send(0, 8'd0, 8'd200);
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.p !== 16'd0) begin
      failures++; $display("FAIL edge_zero: ok=%b got p=%0d want 0", ok, got.p);
    end
    send(1, 8'd1, 8'd255);
    wait_resp(ok, got, ex, lat);
    checks++;
    if (!ok || got !== ex || got.p !== 16'd255 || got.id !== 2'd1) begin
      failures++; $display("FAIL edge_one: ok=%b got id=%0d p=%0d want id=1 p=255", ok, got.id, got.p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stuck();
    test_reset_mid();
    test_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one sequential shift-add multiplier among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the multiplier's level-sensitive `start`/`done` protocol. It returns the product, tagged with the requester ID, over a single valid/ready response port. A watchdog flags a multiplier that never completes. The block sits between the SoC-side clients and the multiplier datapath/control pair.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; the product is `2*WIDTH`.
- `TIMEOUT`, 64: maximum cycles allowed from `mul_start` rising to `mul_done`; must exceed `WIDTH+3`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit is high.
- `req_a`, `req_b` in `NUM_REQ*WIDTH`: flattened operands; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_id` out `$clog2(NUM_REQ)`: requester index of the response.
- `resp_product` out `2*WIDTH`: product.
- `resp_err` out 1: watchdog expired; `resp_product` is 0.
- `mul_start` out 1: level start to the multiplier control.
- `mul_a`, `mul_b` out `WIDTH`: latched operands.
- `mul_done` in 1: multiplier done level.
- `mul_product` in `2*WIDTH`: multiplier result.

## Operation
- States:
  - IDLE: waits for a request.
  - RUN: `mul_start=1`.
  - RELEASE: `mul_start=0`; waits for `mul_done=0`.
  - RESP: holds the response.
- IDLE:
  - `req_ready[i] = grant[i] & ~mul_done`.
  - `grant` is the round-robin one-hot over `req_valid`, searching from `last+1` upward with wrap.
  - On `req_valid[i] & req_ready[i]`: latch `req_a[i]`/`req_b[i]` into `mul_a`/`mul_b`, latch `i` as `resp_id`, set `last=i`, clear the watchdog, go to RUN.
- RUN:
  - The watchdog increments each cycle.
  - If `mul_done=1`: capture `mul_product`, `resp_err=0`, go to RELEASE.
  - Else if watchdog `== TIMEOUT-1`: `resp_product=0`, `resp_err=1`, go to RELEASE.
- RELEASE: when `mul_done=0`, go to RESP and set `resp_valid=1`. This guarantees the multiplier is back in its idle state before the next start.
- RESP: hold `resp_valid` and all response fields stable until `resp_ready`. On the handshake, drop `resp_valid` and go to IDLE.
- Non-granted requesters see `req_ready=0`. A requester may drop `req_valid` before acceptance without effect.
- Arbitration is work-conserving: the only requester valid wins regardless of `last`.
- Reset values:
  - State IDLE.
  - `last = NUM_REQ-1`, so requester 0 has top priority after reset.
  - `mul_start`, `mul_a`, `mul_b`, `resp_valid`, `resp_id`, `resp_product`, `resp_err`, watchdog: all 0.
- Reset mid-operation: all state returns to reset values immediately. The in-flight request is lost and no response is issued.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: `mul_start=1`. The multiplier sequences LOAD, then `WIDTH` SHIFT cycles, then asserts `mul_done` at cycle `WIDTH+3`.
- The cycle after `mul_done` is sampled: `mul_start=0` (RELEASE).
- The multiplier drops `mul_done` one cycle later. `resp_valid` rises the following cycle.
- Nominal latency from accept to `resp_valid` is `WIDTH+6` cycles with `resp_ready` tied high.
- Back-to-back requests: next accept is the cycle after the response handshake. One request is in flight at a time.
- All outputs are registered except `req_ready`, which is combinational from state, `req_valid`, `last` and `mul_done`.
- Simultaneous `mul_done` and watchdog expiry in RUN: `mul_done` wins and `resp_err=0`.
- `resp_ready` asserted outside RESP is ignored.

## Structure
- `mult_sched_pkg` holds:
  - the state encoding constants (IDLE, RUN, RELEASE, RESP; 2 bits);
  - the `ID_W` function (`$clog2` with minimum 1).
- Sub-module `rr_arbiter`, parameterised by `N`:
  - Inputs: `req` vector and `last` pointer.
  - Output: one-hot `grant`.
  - Purely combinational; the `last` register lives in `mult_sched`.
- Top-level integration is outside this block: it inverts `rst_n` for the multiplier's active-high `rst`.

## Test plan
- Single request: requester 2 sends a=13, b=11 -> `resp_id=2`, `resp_product=143`, `resp_err=0`, `resp_valid` 14 cycles after accept (`WIDTH=8`).
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0; each response matches its own operands (e.g. 255*255=65025).
- Back-pressure: hold `resp_ready=0` for 20 cycles -> `resp_valid` and all response fields stable, no new `req_ready`, `mul_start` stays 0.
- Stuck multiplier model (`mul_done` never rises) -> `resp_err=1`, `resp_product=0` after `TIMEOUT` cycles in RUN; the next request proceeds normally.
- Assert `rst_n=0` during RUN -> all outputs 0 asynchronously; after release, requester 0 wins over a simultaneously valid requester 3.
- Edge operands: 0*200 -> 0; 1*255 -> 255.
